fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST words.
- Admits a burst only when the FIFO reports enough room, so a granted burst never hits full.
- Sits directly in front of the FIFO: drives wr_en0/write_data and observes room_avail/full.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the shared FIFO write port. A producer is granted
// a burst of up to MAX_BURST words, and only when the FIFO has room for all of them.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate when someone requests and room >= MAX_BURST
// S_GRANT | owner_q holds the port; its words are written while req stays high
module fifo_wr_arbiter #(
  parameter int FIFO_width = 16,
  parameter int FIFO_ptr   = 3,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_width-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [FIFO_ptr:0]             fifo_room_avail,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_width-1:0]         fifo_write_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [$clog2(MAX_BURST):0]    beat_cnt
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]       BURST_MAX = BW'(MAX_BURST);
  localparam logic [FIFO_ptr:0]   ROOM_MIN  = (FIFO_ptr + 1)'(MAX_BURST);
  localparam logic [OW-1:0]       OWNER_RST = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [BW-1:0]        beat_q;
  logic [BW-1:0]        beat_d;
  // owner_q keeps the last owner after a burst, so it doubles as the round-robin pointer
  logic [OW-1:0]        owner_q;

  logic                  win_found;
  logic [OW-1:0]         win_idx;
  logic                  own_req;
  logic                  own_last;
  logic [FIFO_width-1:0] own_data;
  logic                  wr_en;

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = owner_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(owner_q) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = OW'(idx);
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*FIFO_width +: FIFO_width];
      end
    end
  end

  assign wr_en           = (state_q == S_GRANT) & own_req & ~fifo_full;
  assign beat_d          = beat_q + BW'(1);
  assign fifo_wr_en      = wr_en;
  assign fifo_write_data = (state_q == S_GRANT) ? own_data : '0;
  assign ack             = grant_q & {NUM_REQ{wr_en}};
  assign grant           = grant_q;
  assign busy            = (state_q == S_GRANT);
  assign beat_cnt        = beat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      beat_q  <= '0;
      owner_q <= OWNER_RST;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found && (fifo_room_avail >= ROOM_MIN)) begin
            state_q <= S_GRANT;
            grant_q <= ONE_HOT0 << win_idx;
            owner_q <= win_idx;
            beat_q  <= '0;
          end
        end
        S_GRANT: begin
          if (!own_req) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            beat_q  <= '0;
          end else if (wr_en) begin
            if (own_last || (beat_d == BURST_MAX)) begin
              state_q <= S_IDLE;
              grant_q <= '0;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a burst-level reference model predicts each
// write, and a negedge monitor pops and compares whenever the DUT writes.
module tb_fifo_wr_arbiter;
  localparam int W  = 16;
  localparam int PW = 3;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int BW = $clog2(MB) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [PW:0]      fifo_room_avail;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_write_data;
  logic [N-1:0]     ack;
  logic [N-1:0]     grant;
  logic             busy;
  logic [BW-1:0]    beat_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_width(W), .FIFO_ptr(PW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .fifo_room_avail(fifo_room_avail), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_write_data(fifo_write_data), .ack(ack), .grant(grant), .busy(busy),
    .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] ack;
  } wr_t;

  wr_t wq[$];
  wr_t exp_wr;
  int  checks = 0;
  int  errors = 0;
  int  n_wr   = 0;

  // reference model: burst owner, words written so far, per-producer word sequence
  bit  m_busy;
  int  m_owner;
  int  m_beats;
  int  seq[N];
  bit  exp_we;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i);
    return {4'(i), 12'(seq[i])};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = N - 1;
    m_beats = 0;
  endtask

  // applies the clock edge just taken, using the inputs held during the previous cycle
  task automatic model_advance();
    if (!reset) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (req != '0 && int'(fifo_room_avail) >= MB) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_owner + k) % N;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy  = 1'b0;
      m_beats = 0;
    end else if (!fifo_full) begin
      seq[m_owner]++;
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_busy  = 1'b0;
        m_beats = 0;
      end
    end
  endtask

  task automatic step(input bit rst_v, input logic [N-1:0] r, input logic [N-1:0] l,
                      input int room, input bit full_v);
    @(posedge clk);
    #1;
    model_advance();
    reset           = rst_v;
    req             = r;
    req_last        = l;
    fifo_room_avail = (PW + 1)'(room);
    fifo_full       = full_v;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word_of(i);
    if (!rst_v) model_reset();
    exp_we = rst_v && m_busy && r[m_owner] && !full_v;
    if (exp_we) begin
      exp_wr.data = word_of(m_owner);
      exp_wr.ack  = N'(1) << m_owner;
      wq.push_back(exp_wr);
    end
    #1;
    chk("busy", busy, m_busy);
    chk("grant", grant, m_busy ? (1 << m_owner) : 0);
    chk("beat_cnt", beat_cnt, m_beats);
    chk("wr_en", fifo_wr_en, exp_we);
    if (!rst_v) begin
      chk("rst_wdata", fifo_write_data, 0);
      chk("rst_ack", ack, 0);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      n_wr++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write data=%h ack=%b expected no write", fifo_write_data, ack);
      end else begin
        exp_wr = wq.pop_front();
        chk("wr_data", fifo_write_data, exp_wr.data);
        chk("wr_ack", ack, exp_wr.ack);
      end
    end else if (ack != '0) begin
      chk("ack_without_write", ack, 0);
    end
    if (busy && fifo_full) begin
      checks++;
      errors++;
      $display("FAIL full_in_grant actual=1 expected=0 at %0t", $time);
    end
  end

  int gseq[$];
  int exp_g[5] = '{1, 2, 4, 8, 1};
  int lastg;
  int n0;
  int occ;
  bit rd;
  logic [N-1:0] r_prev;
  logic [N-1:0] r_new;

  initial begin
    reset = 1'b0; req = '0; req_last = '0; req_data = '0;
    fifo_room_avail = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    model_reset();

    // rotation with all producers requesting
    step(0, 4'b1111, 4'b0000, 8, 0);
    step(0, 4'b1111, 4'b0000, 8, 0);
    lastg = 0;
    for (int c = 0; c < 26; c++) begin
      step(1, 4'b1111, 4'b0000, 8, 0);
      if (grant != '0 && int'(grant) != lastg) gseq.push_back(int'(grant));
      lastg = int'(grant);
    end
    chk("rr_grant_count", gseq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gseq.size(); i++) chk("rr_order", gseq[i], exp_g[i]);

    // req_last on the second word
    step(0, 4'b0000, 4'b0000, 8, 0);
    n0 = n_wr;
    step(1, 4'b0100, 4'b0000, 8, 0);
    step(1, 4'b0100, 4'b0000, 8, 0);
    step(1, 4'b0100, 4'b0100, 8, 0);
    step(1, 4'b0000, 4'b0000, 8, 0);
    chk("last_grant_dropped", grant, 0);
    step(1, 4'b0000, 4'b0000, 8, 0);
    @(negedge clk); #1;
    chk("last_write_count", n_wr - n0, 2);

    // insufficient room holds off arbitration
    step(0, 4'b0000, 4'b0000, 8, 0);
    n0 = n_wr;
    for (int c = 0; c < 4; c++) step(1, 4'b0001, 4'b0000, 3, 0);
    @(negedge clk); #1;
    chk("low_room_no_write", n_wr - n0, 0);
    chk("low_room_grant", grant, 0);
    step(1, 4'b0001, 4'b0000, 4, 0);
    step(1, 4'b0001, 4'b0000, 4, 0);
    chk("room4_grant", grant, 1);
    for (int c = 0; c < 5; c++) step(1, 4'b0001, 4'b0000, 4, 0);

    // owner withdraws after one word
    step(0, 4'b0000, 4'b0000, 8, 0);
    step(1, 4'b0011, 4'b0000, 8, 0);
    step(1, 4'b0011, 4'b0000, 8, 0);
    step(1, 4'b0010, 4'b0000, 8, 0);
    chk("withdraw_no_write", fifo_wr_en, 0);
    step(1, 4'b0010, 4'b0000, 8, 0);
    step(1, 4'b0010, 4'b0000, 8, 0);
    chk("withdraw_next_owner", grant, 2);
    for (int c = 0; c < 4; c++) step(1, 4'b0000, 4'b0000, 8, 0);

    // reset in the middle of a burst
    step(0, 4'b0000, 4'b0000, 8, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    chk("mid_beat_before_reset", beat_cnt, 2);
    step(0, 4'b1111, 4'b0000, 8, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_grant", grant, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    step(1, 4'b1111, 4'b0000, 8, 0);
    chk("post_rst_first_grant", grant, 1);

    // randomized traffic
    r_prev = '0;
    for (int c = 0; c < 2000; c++) begin
      r_new = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : r_prev;
      r_prev = r_new;
      step(($urandom_range(0, 199) != 0),
           r_new,
           ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : 8,
           0);
    end

    // saturated producers into a depth-8 FIFO drained every other cycle
    step(0, 4'b0000, 4'b0000, 8, 0);
    occ = 0;
    for (int c = 0; c < 400; c++) begin
      rd = (c % 2 == 0) && (occ > 0);
      step(1, 4'b1111, 4'b0000, 8 - occ, occ == 8);
      occ = occ + int'(exp_we) - int'(rd);
    end
    step(1, 4'b0000, 4'b0000, 8, 0);
    step(1, 4'b0000, 4'b0000, 8, 0);
    @(negedge clk); #1;
    chk("queue_drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
